// File: rtl/mem_port_arbiter.sv
// Shares the single memory_controller port between instruction fetch (port 0) and the LSU (port 1).
// Optional feature: define MEM_ARB_RR_EN for round-robin arbitration (default is LSU > fetch).
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int MASK_W = 4
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    input  logic [MASK_W-1:0] ls_wmask,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              ls_done,
    output logic [1:0]        MEM_rw_flag,
    output logic [ADDR_W-1:0] MEM_addr,
    output logic [DATA_W-1:0] MEM_write_data,
    output logic [MASK_W-1:0] MEM_write_mask,
    input  logic [DATA_W-1:0] MEM_read_data,
    input  logic              MEM_busy,
    input  logic              MEM_done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10
    } state_t;

    localparam logic [1:0] RW_IDLE  = 2'b00;
    localparam logic [1:0] RW_READ  = 2'b01;
    localparam logic [1:0] RW_WRITE = 2'b10;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_LS = 1'b1;

    state_t              state_r;
    state_t              state_nxt_s;
    logic                owner_r;
    logic                owner_nxt_s;
    logic                last_grant_r;
    logic                last_grant_nxt_s;
    logic [1:0]          rw_flag_r;
    logic [1:0]          rw_flag_nxt_s;
    logic [ADDR_W-1:0]   addr_r;
    logic [ADDR_W-1:0]   addr_nxt_s;
    logic [DATA_W-1:0]   wdata_r;
    logic [DATA_W-1:0]   wdata_nxt_s;
    logic [MASK_W-1:0]   wmask_r;
    logic [MASK_W-1:0]   wmask_nxt_s;
    logic [DATA_W-1:0]   if_rdata_r;
    logic [DATA_W-1:0]   if_rdata_nxt_s;
    logic [DATA_W-1:0]   ls_rdata_r;
    logic [DATA_W-1:0]   ls_rdata_nxt_s;
    logic                if_done_r;
    logic                if_done_nxt_s;
    logic                ls_done_r;
    logic                ls_done_nxt_s;
    logic                req_any_s;
    logic                grant_s;

`ifdef MEM_ARB_RR_EN
    // On a tie the port that was not served last wins; a lone requester always wins.
    function automatic logic pick_owner(input logic if_r, input logic ls_r, input logic last_g);
        logic pick;
        if (if_r && ls_r) begin
            pick = ~last_g;
        end else begin
            pick = ls_r;
        end
        return pick;
    endfunction
`else
    // Fixed priority: the LSU always beats fetch.
    function automatic logic pick_owner(input logic if_r, input logic ls_r);
        logic pick;
        if (ls_r) begin
            pick = PORT_LS;
        end else begin
            pick = if_r ? PORT_IF : PORT_LS;
        end
        return pick;
    endfunction
`endif

    // Arbitration decision, only consumed while idle.
    always_comb begin
        req_any_s = if_req | ls_req;
`ifdef MEM_ARB_RR_EN
        grant_s   = pick_owner(if_req, ls_req, last_grant_r);
`else
        grant_s   = pick_owner(if_req, ls_req);
`endif
    end

    // Next-state and next-output logic of the issue FSM.
    always_comb begin
        state_nxt_s      = state_r;
        owner_nxt_s      = owner_r;
        last_grant_nxt_s = last_grant_r;
        rw_flag_nxt_s    = rw_flag_r;
        addr_nxt_s       = addr_r;
        wdata_nxt_s      = wdata_r;
        wmask_nxt_s      = wmask_r;
        if_rdata_nxt_s   = if_rdata_r;
        ls_rdata_nxt_s   = ls_rdata_r;
        if_done_nxt_s    = 1'b0;
        ls_done_nxt_s    = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (req_any_s) begin
                    owner_nxt_s = grant_s;
                    state_nxt_s = ST_ISSUE;
                    if (grant_s == PORT_LS) begin
                        rw_flag_nxt_s = ls_we ? RW_WRITE : RW_READ;
                        addr_nxt_s    = ls_addr;
                        wdata_nxt_s   = ls_wdata;
                        wmask_nxt_s   = ls_wmask;
                    end else begin
                        // Fetch is always a read, whatever ls_we says.
                        rw_flag_nxt_s = RW_READ;
                        addr_nxt_s    = if_addr;
                        wdata_nxt_s   = '0;
                        wmask_nxt_s   = '0;
                    end
                end else begin
                    rw_flag_nxt_s = RW_IDLE;
                end
            end
            ST_ISSUE: begin
                if (MEM_busy) begin
                    state_nxt_s = ST_ISSUE;
                end else begin
                    rw_flag_nxt_s = RW_IDLE;
                    state_nxt_s   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (MEM_done) begin
                    state_nxt_s      = ST_IDLE;
                    last_grant_nxt_s = owner_r;
                    if (owner_r == PORT_LS) begin
                        ls_rdata_nxt_s = MEM_read_data;
                        ls_done_nxt_s  = 1'b1;
                    end else begin
                        if_rdata_nxt_s = MEM_read_data;
                        if_done_nxt_s  = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            default: begin
                state_nxt_s   = ST_IDLE;
                rw_flag_nxt_s = RW_IDLE;
            end
        endcase
    end

    // FSM state, owner and arbitration history.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r      <= ST_IDLE;
            owner_r      <= 1'b0;
            last_grant_r <= 1'b1;
        end else begin
            state_r      <= state_nxt_s;
            owner_r      <= owner_nxt_s;
            last_grant_r <= last_grant_nxt_s;
        end
    end

    // Command registers that drive the MEM_* bus directly.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rw_flag_r <= RW_IDLE;
            addr_r    <= '0;
            wdata_r   <= '0;
            wmask_r   <= '0;
        end else begin
            rw_flag_r <= rw_flag_nxt_s;
            addr_r    <= addr_nxt_s;
            wdata_r   <= wdata_nxt_s;
            wmask_r   <= wmask_nxt_s;
        end
    end

    // Per-requester read data and completion pulses.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            if_rdata_r <= '0;
            ls_rdata_r <= '0;
            if_done_r  <= 1'b0;
            ls_done_r  <= 1'b0;
        end else begin
            if_rdata_r <= if_rdata_nxt_s;
            ls_rdata_r <= ls_rdata_nxt_s;
            if_done_r  <= if_done_nxt_s;
            ls_done_r  <= ls_done_nxt_s;
        end
    end

    assign MEM_rw_flag    = rw_flag_r;
    assign MEM_addr       = addr_r;
    assign MEM_write_data = wdata_r;
    assign MEM_write_mask = wmask_r;
    assign if_rdata       = if_rdata_r;
    assign ls_rdata       = ls_rdata_r;
    assign if_done        = if_done_r;
    assign ls_done        = ls_done_r;

endmodule
